// File: rtl/adder_arbiter.sv
// Round-robin arbiter sharing one registered add/subtract unit among NREQ requesters.
// Each operation walks IDLE -> EXEC -> RESP, so peak throughput is one result per three cycles.
module adder_arbiter #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    input  logic [NREQ-1:0]          req,
    input  logic [NREQ-1:0]          op_sub,
    input  logic [NREQ*WIDTH-1:0]    op_a,
    input  logic [NREQ*WIDTH-1:0]    op_b,
    output logic [NREQ-1:0]          gnt,
    output logic                     busy,
    output logic                     done,
    output logic [$clog2(NREQ)-1:0]  done_id,
    output logic [WIDTH-1:0]         result,
    output logic                     carry
);

    localparam int IDW = $clog2(NREQ);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] EXEC = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    logic [1:0]       state;
    logic [IDW-1:0]   ptr;
    logic [IDW-1:0]   win;
    logic [IDW-1:0]   pick;
    logic             pick_vld;
    logic [WIDTH-1:0] a_lat;
    logic [WIDTH-1:0] b_lat;
    logic             sub_lat;
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] a_arr [NREQ];
    logic [WIDTH-1:0] b_arr [NREQ];

    // Subtract is A + ~B + 1, so the top bit doubles as the "no borrow" flag.
    function automatic logic [WIDTH:0] add_sub(input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b,
                                               input logic             sub);
        logic [WIDTH-1:0] bb;
        bb = sub ? ~b : b;
        return {1'b0, a} + {1'b0, bb} + {{WIDTH{1'b0}}, sub};
    endfunction

    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            a_arr[i] = op_a[i*WIDTH +: WIDTH];
            b_arr[i] = op_b[i*WIDTH +: WIDTH];
        end
    end

    // First set request at or above ptr, wrapping past NREQ-1 back to 0.
    always_comb begin
        int k;
        pick     = '0;
        pick_vld = 1'b0;
        k        = 0;
        for (int i = 0; i < NREQ; i++) begin
            k = int'(ptr) + i;
            if (k >= NREQ) k = k - NREQ;
            if (!pick_vld && req[k[IDW-1:0]]) begin
                pick     = k[IDW-1:0];
                pick_vld = 1'b1;
            end
        end
    end

    assign sum  = add_sub(a_lat, b_lat, sub_lat);
    assign busy = (state != IDLE);
    assign done = (state == RESP);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            ptr     <= '0;
            win     <= '0;
            gnt     <= '0;
            a_lat   <= '0;
            b_lat   <= '0;
            sub_lat <= 1'b0;
            result  <= '0;
            carry   <= 1'b0;
            done_id <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (en && pick_vld) begin
                        gnt     <= NREQ'(1) << pick;
                        a_lat   <= a_arr[pick];
                        b_lat   <= b_arr[pick];
                        sub_lat <= op_sub[pick];
                        win     <= pick;
                        state   <= EXEC;
                    end
                end
                EXEC: begin
                    result  <= sum[WIDTH-1:0];
                    carry   <= sum[WIDTH];
                    done_id <= win;
                    state   <= RESP;
                end
                RESP: begin
                    gnt   <= '0;
                    ptr   <= (win == IDW'(NREQ-1)) ? '0 : win + 1'b1;
                    state <= IDLE;
                end
                default: begin
                    gnt   <= '0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_adder_arbiter.sv
// Scoreboard bench for adder_arbiter: a transaction-level model predicts each grant and result,
// a monitor compares every cycle, and directed sequences cover the corner cases.
module tb_adder_arbiter;

    localparam int NREQ  = 4;
    localparam int WIDTH = 8;

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic                  en = 1'b0;
    logic [NREQ-1:0]       req = '0;
    logic [NREQ-1:0]       op_sub = '0;
    logic [NREQ*WIDTH-1:0] op_a = '0;
    logic [NREQ*WIDTH-1:0] op_b = '0;
    logic [NREQ-1:0]       gnt;
    logic                  busy;
    logic                  done;
    logic [1:0]            done_id;
    logic [WIDTH-1:0]      result;
    logic                  carry;

    adder_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
        .clk(clk), .rst(rst), .en(en), .req(req), .op_sub(op_sub),
        .op_a(op_a), .op_b(op_b), .gnt(gnt), .busy(busy), .done(done),
        .done_id(done_id), .result(result), .carry(carry)
    );

    initial forever #5 clk = ~clk;

    typedef struct {
        int id;
        int res;
        int c;
    } exp_t;

    exp_t q[$];
    int   chk = 0;
    int   err = 0;
    int   cyc = 0;
    int   m_left = 0;
    int   m_ptr = 0;
    int   m_owner = 0;
    int   h_res = 0;
    int   h_c = 0;
    int   h_id = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        chk++;
        if (act !== exp) begin
            err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Reference model: an operation occupies three cycles; winner chosen round-robin from ptr.
    initial forever begin
        @(posedge clk or posedge rst);
        if (rst) begin
            m_left = 0;
            m_ptr  = 0;
            q.delete();
            h_res = 0;
            h_c   = 0;
            h_id  = 0;
        end else if (m_left > 0) begin
            m_left--;
            if (m_left == 0) m_ptr = (m_owner + 1) % NREQ;
        end else if (en && req != 0) begin
            int a, b, k;
            exp_t e;
            k = m_ptr;
            for (int i = 0; i < NREQ; i++) begin
                k = (m_ptr + i) % NREQ;
                if (req[k]) break;
            end
            a = int'(op_a[k*WIDTH +: WIDTH]);
            b = int'(op_b[k*WIDTH +: WIDTH]);
            e.id = k;
            if (op_sub[k]) begin
                e.res = (a - b + 256) % 256;
                e.c   = (a >= b) ? 1 : 0;
            end else begin
                e.res = (a + b) % 256;
                e.c   = (a + b >= 256) ? 1 : 0;
            end
            q.push_back(e);
            m_owner = k;
            m_left  = 2;
        end
    end

    initial forever begin
        @(negedge clk);
        if (!rst) begin
            logic [NREQ-1:0] eg;
            eg = (m_left > 0) ? (NREQ'(1) << m_owner) : '0;
            check("busy", 32'(busy), 32'(m_left > 0));
            check("gnt", 32'(gnt), 32'(eg));
            check("done", 32'(done), 32'(m_left == 1));
            if (done) begin
                if (q.size() == 0) begin
                    check("done_without_op", 32'(done), 32'd0);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    check("done_id", 32'(done_id), e.id);
                    check("result", 32'(result), e.res);
                    check("carry", 32'(carry), e.c);
                    h_res = e.res;
                    h_c   = e.c;
                    h_id  = e.id;
                end
            end else begin
                check("hold_result", 32'(result), h_res);
                check("hold_carry", 32'(carry), h_c);
                check("hold_done_id", 32'(done_id), h_id);
            end
        end
    end

    task automatic step();
        @(negedge clk);
        #2;
    endtask

    task automatic wait_done(input string name, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (done) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check({name, "_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic check_zero_outputs(input string name);
        check({name, "_gnt"}, 32'(gnt), 32'd0);
        check({name, "_busy"}, 32'(busy), 32'd0);
        check({name, "_done"}, 32'(done), 32'd0);
        check({name, "_result"}, 32'(result), 32'd0);
        check({name, "_carry"}, 32'(carry), 32'd0);
        check({name, "_done_id"}, 32'(done_id), 32'd0);
    endtask

    // One isolated operation; operands and req are scrambled right after the grant edge.
    task automatic run_op(input string name, input logic [NREQ-1:0] r, input logic [NREQ-1:0] s,
                          input logic [31:0] a, input logic [31:0] b, input logic [NREQ-1:0] exp_g,
                          input int exp_id, input int exp_res, input int exp_c);
        bit ok;
        req = r; op_sub = s; op_a = a; op_b = b;
        step();
        check({name, "_gnt"}, 32'(gnt), 32'(exp_g));
        req = '0; op_a = $urandom; op_b = $urandom; op_sub = NREQ'($urandom);
        wait_done(name, ok);
        if (ok) begin
            check({name, "_id"}, 32'(done_id), exp_id);
            check({name, "_res"}, 32'(result), exp_res);
            check({name, "_carry"}, 32'(carry), exp_c);
        end
        step();
        step();
    endtask

    initial begin
        bit ok;
        int last;
        #1;
        check_zero_outputs("reset");
        step();
        step();
        rst = 1'b0;
        en  = 1'b1;
        step();

        run_op("single_add", 4'b0001, 4'b0000, 32'h0000_007F, 32'h0000_0001, 4'b0001, 0, 'h80, 0);
        run_op("ovf_add", 4'b0100, 4'b0000, 32'h00FF_0000, 32'h0002_0000, 4'b0100, 2, 'h01, 1);
        run_op("sub_borrow", 4'b0010, 4'b0010, 32'h0000_0500, 32'h0000_0700, 4'b0010, 1, 'hFE, 0);
        run_op("stable", 4'b0001, 4'b0000, 32'h0000_0010, 32'h0000_0020, 4'b0001, 0, 'h30, 0);

        // Fairness from a freshly reset pointer.
        rst = 1'b1;
        req = 4'b1111; op_a = $urandom; op_b = $urandom; op_sub = NREQ'($urandom);
        step();
        rst = 1'b0;
        last = 0;
        for (int i = 0; i < 12; i++) begin
            wait_done("fair", ok);
            if (!ok) break;
            check("fair_order", 32'(done_id), i % NREQ);
            if (i > 0) check("fair_spacing", cyc - last, 3);
            last = cyc;
        end
        req = '0;
        step(); step(); step();

        // Reset while the operation is in EXEC.
        req = 4'b0001;
        step();
        req = 4'b1010;
        rst = 1'b1;
        #1;
        check_zero_outputs("rst_exec");
        step();
        rst = 1'b0;
        step();
        check("post_rst_gnt", 32'(gnt), 32'(4'b0010));
        req = '0;
        step(); step(); step();

        en  = 1'b0;
        req = 4'b0100;
        for (int i = 0; i < 5; i++) begin
            step();
            check("en_low_gnt", 32'(gnt), 32'd0);
        end
        en = 1'b1;
        step();
        check("en_rise_gnt", 32'(gnt), 32'(4'b0100));
        req = '0;
        step(); step(); step();

        for (int i = 0; i < 400; i++) begin
            req    = NREQ'($urandom);
            en     = ($urandom_range(0, 3) != 0);
            op_sub = NREQ'($urandom);
            op_a   = $urandom;
            op_b   = $urandom;
            step();
        end
        req = '0;
        en  = 1'b1;
        for (int i = 0; i < 6; i++) step();
        check("queue_drained", 32'(q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", chk, err);
        $finish;
    end

endmodule
